// File: rtl/keypad_event_capture_if.sv
// Key-event stream from keypad_event_capture to its consumer.
// The consumer takes the head event when evt_valid && evt_ready.
interface keypad_event_capture_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_code;
    logic       evt_repeat;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_repeat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_repeat,
        output evt_ready
    );
endinterface

// File: rtl/keypad_event_capture.sv
// Turns the active-low keypad encoder code into debounced press/change/repeat events.
// The events are queued in a small FIFO that drives a valid/ready interface.
module keypad_event_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD   = 200,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          Y3_n,
    input  logic                          Y2_n,
    input  logic                          Y1_n,
    input  logic                          Y0_n,
    keypad_event_capture_if.master        evt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          key_held,
    output logic [3:0]                    held_code
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CNT_W-1:0] DebLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);
    localparam bit               RepeatEn   = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {StIdle, StDeb, StHeld, StRel} state_e;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] code_raw, code_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= {Y3_n, Y2_n, Y1_n, Y0_n};
            sync2_q <= sync1_q;
        end
    end

    // Codes above 9 are not real keys and read as "no key".
    assign code_raw = ~sync2_q;
    assign code_s   = (code_raw > 4'd9) ? 4'd0 : code_raw;

    // ------------------------------------------------------------------
    // Debounce / repeat FSM
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [3:0]       cand_q;
    logic [CNT_W-1:0] deb_q;
    logic [CNT_W-1:0] rep_q;
    logic             first_q;
    logic [3:0]       held_code_q;

    logic [CNT_W-1:0] rep_limit;
    logic             rep_hit;
    logic             push;
    logic [3:0]       push_code;
    logic             push_rep;

    always_comb begin
        rep_limit = first_q ? DelayLast : PeriodLast;
        rep_hit   = RepeatEn && (state_q == StHeld) && (code_s == held_code_q) &&
                    (rep_q == rep_limit);
        push      = 1'b0;
        push_code = 4'd0;
        push_rep  = 1'b0;
        case (state_q)
            StDeb: begin
                if ((code_s != 4'd0) && (code_s == cand_q) && (deb_q == DebLast)) begin
                    push      = 1'b1;
                    push_code = cand_q;
                end
            end
            StHeld: begin
                if (rep_hit) begin
                    push      = 1'b1;
                    push_code = held_code_q;
                    push_rep  = 1'b1;
                end
            end
            StRel: begin
                if ((code_s != held_code_q) && (code_s == cand_q) && (deb_q == DebLast) &&
                    (cand_q != 4'd0)) begin
                    push      = 1'b1;
                    push_code = cand_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            deb_q       <= '0;
            rep_q       <= '0;
            first_q     <= 1'b0;
            held_code_q <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (code_s != 4'd0) begin
                        state_q <= StDeb;
                        cand_q  <= code_s;
                        deb_q   <= CNT_W'(1);
                    end
                end
                StDeb: begin
                    if (code_s == 4'd0) begin
                        state_q <= StIdle;
                    end else if (code_s != cand_q) begin
                        cand_q <= code_s;
                        deb_q  <= CNT_W'(1);
                    end else if (deb_q == DebLast) begin
                        state_q     <= StHeld;
                        held_code_q <= cand_q;
                        rep_q       <= '0;
                        first_q     <= 1'b1;
                    end else begin
                        deb_q <= deb_q + CNT_W'(1);
                    end
                end
                StHeld: begin
                    if (code_s == held_code_q) begin
                        if (RepeatEn) begin
                            if (rep_hit) begin
                                rep_q   <= '0;
                                first_q <= 1'b0;
                            end else begin
                                rep_q <= rep_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        state_q <= StRel;
                        cand_q  <= code_s;
                        deb_q   <= CNT_W'(1);
                    end
                end
                StRel: begin
                    // A bounce back to the held key resumes HELD without a new event.
                    if (code_s == held_code_q) begin
                        state_q <= StHeld;
                        rep_q   <= '0;
                        first_q <= 1'b1;
                    end else if (code_s != cand_q) begin
                        cand_q <= code_s;
                        deb_q  <= CNT_W'(1);
                    end else if (deb_q == DebLast) begin
                        if (cand_q == 4'd0) begin
                            state_q     <= StIdle;
                            held_code_q <= 4'd0;
                        end else begin
                            state_q     <= StHeld;
                            held_code_q <= cand_q;
                            rep_q       <= '0;
                            first_q     <= 1'b1;
                        end
                    end else begin
                        deb_q <= deb_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign key_held  = (state_q == StHeld);
    assign held_code = held_code_q;

    // ------------------------------------------------------------------
    // Event FIFO with registered head
    // ------------------------------------------------------------------
    logic [4:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            valid_q;
    logic [3:0]      head_code_q;
    logic            head_rep_q;
    logic            overflow_q;

    logic            pop, full, do_push, drop;
    logic [4:0]      head_d;

    always_comb begin
        pop      = valid_q && evt.evt_ready;
        full     = (count_q == CntW'(FIFO_DEPTH));
        do_push  = push && (!full || pop);
        drop     = push && full && !pop;
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(do_push) - CntW'(pop);
        // The slot being written is the next head only when the FIFO drains to it.
        if (do_push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = {push_code, push_rep};
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        if (count_d == '0) begin
            head_d = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 5'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            head_code_q <= 4'd0;
            head_rep_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_code, push_rep};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= (count_d != '0);
            head_code_q <= head_d[4:1];
            head_rep_q  <= head_d[0];
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign evt.evt_valid  = valid_q;
    assign evt.evt_code   = head_code_q;
    assign evt.evt_repeat = head_rep_q;
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_keypad_event_capture.sv
// Directed plus randomized bench for keypad_event_capture; the reference model works on
// run lengths of the synchronised code and an event queue rather than an explicit FSM.
module tb_keypad_event_capture;

    localparam int unsigned DEB   = 4;
    localparam int unsigned DLY   = 20;
    localparam int unsigned PER   = 10;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] y = 4'hF;
    logic       clr = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       key_held;
    logic [3:0] held_code;

    keypad_event_capture_if bus ();

    keypad_event_capture #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DLY),
        .REPEAT_PERIOD  (PER),
        .FIFO_DEPTH     (DEPTH),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Y3_n        (y[3]),
        .Y2_n        (y[2]),
        .Y1_n        (y[1]),
        .Y0_n        (y[0]),
        .evt         (bus),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .clr_overflow(clr),
        .key_held    (key_held),
        .held_code   (held_code)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_acc;      // accepted key, 0 = none
    int         m_run_v;    // value of the current run of equal samples
    int         m_run_n;    // length of that run
    int         m_k;        // samples spent holding the accepted key
    bit         m_held;
    logic [3:0] m_yd1, m_yd2;
    logic [4:0] m_q[$];
    bit         m_ovf;

    int n_vec = 0;
    int n_miss = 0;
    int seen = 0;
    int last_code = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_run_v = 0; m_run_n = 0; m_k = 0; m_held = 0;
        m_yd1 = 4'hF; m_yd2 = 4'hF;
        m_q.delete();
        m_ovf = 0;
    endtask

    task automatic model_update();
        logic [3:0] c;
        int         s;
        bit         ev, ev_rep, pop;
        c = ~m_yd2;
        s = (c > 4'd9) ? 0 : int'(c);
        m_yd2 = m_yd1;
        m_yd1 = y;
        ev = 0; ev_rep = 0;
        if (s == m_run_v) m_run_n++;
        else begin m_run_v = s; m_run_n = 1; end
        if (m_held) begin
            if (s == m_acc) begin
                m_k++;
                if (m_k == DLY || (m_k > DLY && (m_k - DLY) % PER == 0)) begin
                    ev = 1; ev_rep = 1;
                end
            end else m_held = 0;
        end else if (m_acc != 0 && s == m_acc) begin
            m_held = 1; m_k = 0;
        end else if (s != m_acc && m_run_n == DEB) begin
            m_acc = s;
            if (s != 0) begin ev = 1; m_held = 1; m_k = 0; end
        end
        pop = (m_q.size() != 0) && bus.evt_ready;
        if (pop) void'(m_q.pop_front());
        if (ev && m_q.size() == DEPTH) m_ovf = 1;
        else begin
            if (ev) m_q.push_back({4'(m_acc), ev_rep});
            if (clr) m_ovf = 0;
        end
    endtask

    task automatic check_all();
        logic [4:0] h;
        h = (m_q.size() != 0) ? m_q[0] : 5'd0;
        chk("evt_valid",  32'(bus.evt_valid),  32'(m_q.size() != 0));
        chk("evt_code",   32'(bus.evt_code),   32'(h[4:1]));
        chk("evt_repeat", 32'(bus.evt_repeat), 32'(h[0]));
        chk("fifo_count", 32'(fifo_count),     32'(m_q.size()));
        chk("overflow",   32'(overflow),       32'(m_ovf));
        chk("key_held",   32'(key_held),       32'(m_held));
        chk("held_code",  32'(held_code),      32'(m_acc));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
        if (bus.evt_valid && bus.evt_ready) begin
            seen++;
            last_code = int'(bus.evt_code);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"},  32'(bus.evt_valid),  32'd0);
        chk({tag, "_code"},   32'(bus.evt_code),   32'd0);
        chk({tag, "_rep"},    32'(bus.evt_repeat), 32'd0);
        chk({tag, "_count"},  32'(fifo_count),     32'd0);
        chk({tag, "_ovf"},    32'(overflow),       32'd0);
        chk({tag, "_held"},   32'(key_held),       32'd0);
        chk({tag, "_hcode"},  32'(held_code),      32'd0);
    endtask

    initial begin
        int rep_seen;
        int ready_pct;
        model_reset();
        bus.evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // 1: key 9 press, consumer stalled
        y = 4'b0110;
        cycles(5);
        chk("t1_valid_edge5", 32'(bus.evt_valid), 32'd0);
        cycle();
        chk("t1_valid_edge6", 32'(bus.evt_valid), 32'd1);
        chk("t1_code", 32'(bus.evt_code), 32'd9);
        chk("t1_rep", 32'(bus.evt_repeat), 32'd0);
        chk("t1_count", 32'(fifo_count), 32'd1);
        chk("t1_held", 32'(key_held), 32'd1);
        chk("t1_hcode", 32'(held_code), 32'd9);
        y = 4'hF;
        bus.evt_ready = 1'b1;
        cycles(10);

        // 2: chatter never reaches the debounce count
        for (int i = 0; i < 10; i++) begin
            y = (i % 2 == 0) ? 4'b0110 : 4'hF;
            cycles(2);
        end
        y = 4'hF;
        cycles(8);
        chk("t2_hcode", 32'(held_code), 32'd0);
        chk("t2_held", 32'(key_held), 32'd0);
        chk("t2_count", 32'(fifo_count), 32'd0);

        // 3: auto-repeat of key 5
        y = 4'b1010;
        cycles(6);
        chk("t3_held", 32'(key_held), 32'd1);
        chk("t3_code", 32'(bus.evt_code), 32'd5);
        rep_seen = 0;
        for (int i = 0; i < 59; i++) begin
            cycle();
            if (bus.evt_valid && bus.evt_repeat) rep_seen++;
        end
        chk("t3_repeats", 32'(rep_seen), 32'd4);
        y = 4'hF;
        cycles(10);

        // 4: overflow with five presses and a stalled consumer
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] codes [5];
            codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
            y = ~codes[i];
            cycles(8);
            y = 4'hF;
            cycles(8);
        end
        chk("t4_count", 32'(fifo_count), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_head", 32'(bus.evt_code), 32'd1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        bus.evt_ready = 1'b1;
        cycles(4);
        chk("t4_empty", 32'(fifo_count), 32'd0);
        chk("t4_valid", 32'(bus.evt_valid), 32'd0);

        // 5: short glitch to 7 is ignored, a stable 7 is accepted
        y = ~4'd3;
        cycles(8);
        seen = 0;
        y = ~4'd7;
        cycles(2);
        y = ~4'd3;
        cycles(6);
        chk("t5_glitch_events", 32'(seen), 32'd0);
        y = ~4'd7;
        cycles(8);
        chk("t5_events", 32'(seen), 32'd1);
        chk("t5_code", 32'(last_code), 32'd7);
        chk("t5_hcode", 32'(held_code), 32'd7);
        y = 4'hF;
        cycles(8);

        // 6: code 10 is idle; reset in the middle of a debounce
        seen = 0;
        y = 4'b0101;
        cycles(10);
        chk("t6_code10_events", 32'(seen), 32'd0);
        chk("t6_code10_held", 32'(key_held), 32'd0);
        y = ~4'd2;
        cycles(3);
        #2;
        rst_n = 1'b0;
        y = 4'hF;
        #1;
        chk_zero_outputs("t6_rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(10);
        chk("t6_after_events", 32'(seen), 32'd0);
        chk("t6_after_hcode", 32'(held_code), 32'd0);

        // Randomized segments against the model
        for (int seg = 0; seg < 150; seg++) begin
            int len, r;
            logic [3:0] code;
            r = int'($urandom_range(0, 15));
            if (r < 3) code = 4'd0;
            else if (r < 13) code = 4'($urandom_range(1, 9));
            else code = 4'($urandom_range(10, 15));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 60))
                                              : int'($urandom_range(1, 10));
            ready_pct = int'($urandom_range(0, 100));
            y = ~code;
            for (int i = 0; i < len; i++) begin
                bus.evt_ready = ($urandom_range(0, 99) < ready_pct);
                clr = ($urandom_range(0, 15) == 0);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
